// File: rtl/serial_pkg.sv
// Shared definitions for the serial path: serializer and downstream detector
// state encodings plus width helpers.
package serial_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } ser_state_t;

    typedef enum logic [1:0] {
        DET_IDLE = 2'b00,
        DET_SAW0 = 2'b01,
        DET_SAW1 = 2'b10
    } det_state_t;

    function automatic int unsigned clog2(input int unsigned value);
        int unsigned result;
        result = 0;
        while ((64'd1 << result) < 64'(value)) result++;
        return result;
    endfunction

endpackage

// File: rtl/bit_serializer.sv
// Parallel-to-serial converter with a one-entry hold register in front of the
// shifter, so the next word can be staged while the current one is shifting.
module bit_serializer
    import serial_pkg::*;
#(
    parameter int unsigned WIDTH      = 8,
    parameter int unsigned MSB_FIRST  = 1,
    parameter logic        IDLE_LEVEL = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic             ser_out,
    output logic             ser_valid,
    output logic             word_done,
    output logic             busy
);

    localparam int unsigned     CW       = clog2(WIDTH);
    localparam logic [CW-1:0]   LAST_BIT = CW'(WIDTH - 1);
    localparam logic [CW-1:0]   PENULT   = CW'(WIDTH - 2);

    ser_state_t       state, state_nxt;
    logic [WIDTH-1:0] hold_data;
    logic             hold_valid;
    logic [WIDTH-1:0] shreg;
    logic [WIDTH-1:0] src;
    logic [WIDTH-1:0] src_shifted;
    logic             head_bit;
    logic [CW-1:0]    bit_cnt;
    logic             load;
    logic             advance;
    logic             accept;

    assign in_ready = ~hold_valid;
    assign accept   = in_valid & in_ready;
    assign busy     = (state == SHIFT) | hold_valid;

    always_comb begin
        state_nxt = state;
        load      = 1'b0;
        advance   = 1'b0;
        unique case (state)
            IDLE: begin
                if (hold_valid) begin
                    load      = 1'b1;
                    state_nxt = SHIFT;
                end
            end
            SHIFT: begin
                if (bit_cnt == LAST_BIT) begin
                    if (hold_valid) load = 1'b1;
                    else            state_nxt = IDLE;
                end else begin
                    advance = 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // shreg holds only the bits not yet emitted, head-aligned; ser_out is the
    // registered head so the first bit appears on the load edge itself.
    always_comb begin
        src = load ? hold_data : shreg;
        if (MSB_FIRST != 0) begin
            head_bit    = src[WIDTH-1];
            src_shifted = {src[WIDTH-2:0], 1'b0};
        end else begin
            head_bit    = src[0];
            src_shifted = {1'b0, src[WIDTH-1:1]};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hold_data  <= '0;
            hold_valid <= 1'b0;
        end else if (accept) begin
            hold_data  <= in_data;
            hold_valid <= 1'b1;
        end else if (load) begin
            hold_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shreg     <= '0;
            bit_cnt   <= '0;
            ser_out   <= IDLE_LEVEL;
            ser_valid <= 1'b0;
            word_done <= 1'b0;
        end else if (load || advance) begin
            shreg     <= src_shifted;
            ser_out   <= head_bit;
            ser_valid <= 1'b1;
            bit_cnt   <= load ? '0 : bit_cnt + 1'b1;
            word_done <= advance && (bit_cnt == PENULT);
        end else begin
            bit_cnt   <= '0;
            ser_out   <= IDLE_LEVEL;
            ser_valid <= 1'b0;
            word_done <= 1'b0;
        end
    end

endmodule
